// File: rtl/reg_map.sv
// reg_map: ten 8-bit equalizer band gains written through a single-cycle write port
module reg_map (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] gain_1,
  output logic [7:0] gain_2,
  output logic [7:0] gain_3,
  output logic [7:0] gain_4,
  output logic [7:0] gain_5,
  output logic [7:0] gain_6,
  output logic [7:0] gain_7,
  output logic [7:0] gain_8,
  output logic [7:0] gain_9,
  output logic [7:0] gain_10
);
  logic [7:0] r_gain [10];
  logic       w_hit;
  assign w_hit = we && (addr < 8'd10);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_gain <= '{default: 8'h00};
    else if (w_hit) r_gain[addr[3:0]] <= data_in;
  assign gain_1  = r_gain[0];
  assign gain_2  = r_gain[1];
  assign gain_3  = r_gain[2];
  assign gain_4  = r_gain[3];
  assign gain_5  = r_gain[4];
  assign gain_6  = r_gain[5];
  assign gain_7  = r_gain[6];
  assign gain_8  = r_gain[7];
  assign gain_9  = r_gain[8];
  assign gain_10 = r_gain[9];
endmodule

// File: tb/tb_reg_map.sv
// tb_reg_map: directed self-checking bench for the equalizer gain register file
module tb_reg_map;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] gain_1, gain_2, gain_3, gain_4, gain_5;
  logic [7:0] gain_6, gain_7, gain_8, gain_9, gain_10;
  logic [79:0] w_all;
  int checks = 0;
  int errors = 0;

  reg_map dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data_in(data_in),
    .gain_1(gain_1), .gain_2(gain_2), .gain_3(gain_3), .gain_4(gain_4),
    .gain_5(gain_5), .gain_6(gain_6), .gain_7(gain_7), .gain_8(gain_8),
    .gain_9(gain_9), .gain_10(gain_10)
  );

  always #5 clk = ~clk;

  assign w_all = {gain_10, gain_9, gain_8, gain_7, gain_6,
                  gain_5, gain_4, gain_3, gain_2, gain_1};

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    data_in = d;
  endtask

  task automatic idle;
    @(negedge clk);
    we = 1'b0;
  endtask

  localparam logic [79:0] FILL = {8'h12, 8'h10, 8'h0E, 8'h0C, 8'h0A,
                                  8'h08, 8'h06, 8'h04, 8'h02, 8'h00};
  localparam logic [79:0] OVER = {8'h3C, 8'h10, 8'h0E, 8'h0C, 8'h0A,
                                  8'h08, 8'h06, 8'h04, 8'h02, 8'h00};

  initial begin
    #12;
    check("in_reset", w_all, 80'h0);
    #8 rst_n = 1'b1;
    @(negedge clk);
    check("reset_vals", w_all, 80'h0);
    for (int i = 0; i < 10; i++) begin
      wr(8'(i), 8'(2 * i));
      if (i == 6) begin
        check("fill_g6_latency", {72'h0, gain_6}, 80'h0A);
        check("fill_g7_untouched", {72'h0, gain_7}, 80'h00);
      end
    end
    idle;
    check("seq_fill", w_all, FILL);
    wr(8'h0A, 8'hFF);
    wr(8'hFF, 8'hFF);
    wr(8'h10, 8'hFF);
    wr(8'h13, 8'hFF);
    idle;
    check("unmapped", w_all, FILL);
    addr = 8'h03;
    data_in = 8'h55;
    repeat (4) @(negedge clk);
    check("we_low_g4", {72'h0, gain_4}, 80'h06);
    check("we_low_all", w_all, FILL);
    wr(8'h09, 8'hA5);
    wr(8'h09, 8'h3C);
    check("over_first", {72'h0, gain_10}, 80'hA5);
    idle;
    check("over_second", {72'h0, gain_10}, 80'h3C);
    check("over_isolation", w_all, OVER);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", w_all, 80'h0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("stay_zero", w_all, 80'h0);
    wr(8'h02, 8'h77);
    rst_n = 1'b0;
    @(negedge clk);
    check("write_in_reset_lost", w_all, 80'h0);
    rst_n = 1'b1;
    addr = 8'h00;
    data_in = 8'h11;
    @(negedge clk);
    we = 1'b0;
    check("first_write_after_reset", w_all, 80'h11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
